jk_bank_sched: RTL and testbench

- Round-robin scheduler that shares one bank of J-K flip-flop bits between NREQ requesters.
- Each requester submits one J-K command: an opcode (HOLD/RESET/SET/TOGGLE) and a bit index.
- The block arbitrates, applies the winning command to the addressed bit, and returns a one-cycle grant.
- Sits between control-path requesters and any logic consuming the shared flag bank q/q_n.

---
 rtl/jk_bank_sched.sv | 176 +++++++++++++++++
 tb/tb_jk_bank_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler that applies HOLD/RESET/SET/TOGGLE commands from NREQ
// requesters to one shared bank of J-K bits. Define JKS_OPCNT_EN to add op_cnt.
module jk_bank_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [IDX_W*NREQ-1:0] idx,
    output logic [NREQ-1:0]       gnt,
    output logic                  err,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      q_n
`ifdef JKS_OPCNT_EN
    ,
    output logic [15:0]           op_cnt
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        APPLY
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_RESET  = 2'd1,
        OP_SET    = 2'd2,
        OP_TOGGLE = 2'd3
    } op_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic [1:0]       op_arr  [NREQ];
    logic [IDX_W-1:0] idx_arr [NREQ];
    logic [NREQ-1:0]  req_rot;
    logic             found;
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   pick_sum;
    logic [PTR_W-1:0] pick;
    logic             in_range;
    logic [WIDTH-1:0] sel;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i]  = op[2*i +: 2];
            idx_arr[i] = idx[IDX_W*i +: IDX_W];
        end
    end

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        req_rot  = NREQ'({req, req} >> ptr_q);
        found    = 1'b0;
        off      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found = 1'b1;
                off   = PTR_W'(i);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, off};
        if (pick_sum >= (PTR_W+1)'(NREQ))
            pick_sum = pick_sum - (PTR_W+1)'(NREQ);
        pick     = pick_sum[PTR_W-1:0];
    end

    assign in_range = (32'(idx_q) < WIDTH);
    assign sel      = WIDTH'(1) << idx_q;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        gnt_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    op_d    = op_e'(op_arr[pick]);
                    idx_d   = idx_arr[pick];
                    busy_d  = 1'b1;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (in_range) begin
                    case (op_q)
                        OP_RESET:  q_d = q_q & ~sel;
                        OP_SET:    q_d = q_q | sel;
                        OP_TOGGLE: q_d = q_q ^ sel;
                        default:   q_d = q_q;
                    endcase
                end
                gnt_d   = NREQ'(1) << win_q;
                err_d   = !in_range;
                ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
        end
    end

    // NOTE: the captured command needs no reset; APPLY is only ever entered through a capture.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        op_q  <= op_d;
        idx_q <= idx_d;
    end

    assign gnt  = gnt_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign q    = q_q;
    assign q_n  = ~q_q;

`ifdef JKS_OPCNT_EN
    logic [15:0] op_cnt_q, op_cnt_d;

    // Counts effective commands only; holds at all-ones.
    always_comb begin
        op_cnt_d = op_cnt_q;
        if (state_q == APPLY && in_range && op_q != OP_HOLD && op_cnt_q != 16'hFFFF)
            op_cnt_d = op_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (clr) op_cnt_q <= '0;
        else     op_cnt_q <= op_cnt_d;
    end

    assign op_cnt = op_cnt_q;
`else
    // Default build: no command counter.
`endif

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed literal sequences plus random requesters,
// all checked every cycle against a transaction-level model of the scheduler.
module tb_jk_bank_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDX_W = 4;

    bit                    clk;
    logic                  clr;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [IDX_W*NREQ-1:0] idx;
    logic [NREQ-1:0]       gnt;
    logic                  err;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_n;
`ifdef JKS_OPCNT_EN
    logic [15:0]           op_cnt;
`endif

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    jk_bank_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk    (clk),
        .clr    (clr),
        .req    (req),
        .op     (op),
        .idx    (idx),
        .gnt    (gnt),
        .err    (err),
        .busy   (busy),
        .q      (q),
        .q_n    (q_n)
`ifdef JKS_OPCNT_EN
        ,
        .op_cnt (op_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: a pending command, a pointer and an integer bank.
    int m_bank, m_ptr, m_win, m_op, m_idx, m_cnt, e_gnt;
    bit m_pending, m_valid, e_err, e_busy;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (clr) begin
            m_bank = 0; m_ptr = 0; m_pending = 0; m_cnt = 0;
            e_gnt = 0; e_err = 0; e_busy = 0;
        end else if (m_pending) begin
            if (m_idx < WIDTH) begin
                case (m_op)
                    1: m_bank = m_bank & ~(1 << m_idx);
                    2: m_bank = m_bank | (1 << m_idx);
                    3: m_bank = m_bank ^ (1 << m_idx);
                    default: ;
                endcase
                if (m_op != 0 && m_cnt < 65535) m_cnt++;
            end
            e_gnt = 1 << m_win;
            e_err = (m_idx >= WIDTH);
            e_busy = 0;
            m_ptr = (m_win + 1) % NREQ;
            m_pending = 0;
        end else begin
            e_gnt = 0; e_err = 0;
            for (int k = 0; k < NREQ; k++) begin
                int r;
                r = (m_ptr + k) % NREQ;
                if (!m_pending && ((int'(req) >> r) & 1) == 1) begin
                    m_pending = 1;
                    m_win = r;
                    m_op  = (int'(op) >> (2 * r)) & 3;
                    m_idx = (int'(idx) >> (IDX_W * r)) & ((1 << IDX_W) - 1);
                end
            end
            e_busy = m_pending;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_gnt",  32'(gnt),  32'(e_gnt));
            check("m_err",  32'(err),  32'(e_err));
            check("m_busy", 32'(busy), 32'(e_busy));
            check("m_q",    32'(q),    32'(m_bank & 255));
            check("m_q_n",  32'(q_n),  32'(~m_bank & 255));
`ifdef JKS_OPCNT_EN
            check("m_op_cnt", 32'(op_cnt), 32'(m_cnt));
`endif
        end
    end

    // Issue one command from requester r alone; expects grant two clocks later.
    task automatic do_cmd(input int r, input logic [1:0] o, input logic [IDX_W-1:0] ix,
                          input logic [7:0] exp_q, input logic exp_err);
        req = '0;
        req[r] = 1'b1;
        op[2*r +: 2] = o;
        idx[IDX_W*r +: IDX_W] = ix;
        @(negedge clk);
        check("cmd_busy", 32'(busy), 32'd1);
        check("cmd_gnt_early", 32'(gnt), 32'd0);
        @(negedge clk);
        check("cmd_gnt", 32'(gnt), 32'(1 << r));
        check("cmd_err", 32'(err), 32'(exp_err));
        check("cmd_q", 32'(q), 32'(exp_q));
        check("cmd_busy_done", 32'(busy), 32'd0);
        req = '0;
    endtask

    int rr_gnt[10] = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};
    int rr_q[10]   = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h03, 8'h07, 8'h07, 8'h0F, 8'h0F, 8'h0F};

    initial begin
        clr = 1'b1;
        req = '1;
        op  = '0;
        idx = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_q",    32'(q),    32'h00);
            check("rst_q_n",  32'(q_n),  32'hFF);
            check("rst_gnt",  32'(gnt),  32'h0);
            check("rst_busy", 32'(busy), 32'h0);
        end

        // All four requesting, requester r sets bit r.
        for (int r = 0; r < NREQ; r++) begin
            op[2*r +: 2] = 2'd2;
            idx[IDX_W*r +: IDX_W] = IDX_W'(r);
        end
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rr_gnt", 32'(gnt), 32'(rr_gnt[i]));
            check("rr_q", 32'(q), 32'(rr_q[i]));
        end

        req = '0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        do_cmd(0, 2'd2, 4'd3, 8'h08, 1'b0);
        do_cmd(0, 2'd3, 4'd3, 8'h00, 1'b0);
        do_cmd(0, 2'd1, 4'd3, 8'h00, 1'b0);
        do_cmd(0, 2'd0, 4'd3, 8'h00, 1'b0);
        do_cmd(2, 2'd2, 4'd9, 8'h00, 1'b1);

        // Reset lands on the APPLY edge of requester 1.
        req = 4'b0010;
        op  = 8'b0000_1000;
        idx = '0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        req = '0;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_q", 32'(q), 32'h00);
        check("midrst_busy_clr", 32'(busy), 32'd0);
        clr = 1'b0;
        req = 4'b1010;
        op  = '0;
        @(negedge clk);
        @(negedge clk);
        check("ptr_after_clr", 32'(gnt), 32'b0010);
        req = '0;

        do_cmd(0, 2'd2, 4'd1,  8'h02, 1'b0);
        do_cmd(0, 2'd0, 4'd1,  8'h02, 1'b0);
        do_cmd(0, 2'd3, 4'd1,  8'h00, 1'b0);
        do_cmd(0, 2'd2, 4'd12, 8'h00, 1'b1);
`ifdef JKS_OPCNT_EN
        check("op_cnt_seq", 32'(op_cnt), 32'd2);
`endif

        // Random requesters obeying the handshake, with occasional clr.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            clr = ($urandom_range(0, 199) == 0);
            for (int r = 0; r < NREQ; r++) begin
                if (!req[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[r] = 1'b1;
                        op[2*r +: 2] = 2'($urandom_range(0, 3));
                        idx[IDX_W*r +: IDX_W] = IDX_W'($urandom_range(0, 11));
                    end
                end else if (gnt[r]) begin
                    if ($urandom_range(0, 3) != 0) req[r] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    op[2*r +: 2] = 2'($urandom_range(0, 3));
                    idx[IDX_W*r +: IDX_W] = IDX_W'($urandom_range(0, 11));
                end else if ($urandom_range(0, 63) == 0) begin
                    req[r] = 1'b0;
                end
            end
        end
        clr = 1'b0;
        req = '0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
